// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared definitions for the cache miss controller:
//   - state_t   : controller states (IDLE, FETCH, FILL)
//   - INDEX_* / TAG_* : bit ranges of the cache index and tag in a CPU address
//   - line_addr : returns the line-aligned (word offset cleared) address
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    localparam int INDEX_LSB = 2;
    localparam int INDEX_MSB = 11;
    localparam int TAG_LSB   = 12;
    localparam int TAG_MSB   = 14;
    localparam int LINE_ADDR_W = TAG_MSB + 1;

    // Clears the bits below the index so memory sees the start of the line.
    function automatic logic [LINE_ADDR_W-1:0] line_addr(input logic [LINE_ADDR_W-1:0] addr);
        return {addr[LINE_ADDR_W-1:INDEX_LSB], {INDEX_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : clock
//   rst   : synchronous active-low reset, clears the count
//   inc   : increment request for this cycle
//   count : current count value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_miss_controller.sv
// ---------------------------------------------------------------------------
// cache_miss_controller
// Sequencer between the CPU read port, a direct-mapped cache array and the
// backing memory. Hits complete in the request cycle; misses stall the CPU,
// fetch the 128-bit line from memory, write it into the cache and then let
// the retried access complete. Keeps saturating hit and miss counters.
//
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   cpu_req, cpu_addr : CPU read request and address
//   cpu_ready         : access completes this cycle
//   cache_miss        : combinational miss flag for cache_addr
//   cache_addr        : address driven to the cache
//   cache_write       : one-cycle line write strobe
//   cache_wdata       : line written into the cache
//   mem_rd, mem_addr  : memory line read request and line-aligned address
//   mem_ready         : memory data valid
//   mem_data          : memory line data
//   hit_count         : saturating hit counter
//   miss_count        : saturating miss counter
// ---------------------------------------------------------------------------
module cache_miss_controller
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int LINE_W = 128,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ready,
    input  logic              cache_miss,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_write,
    output logic [LINE_W-1:0] cache_wdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    state_t            state;
    state_t            state_next;
    logic              refill_q;
    logic [ADDR_W-1:0] miss_addr_q;
    logic [LINE_W-1:0] line_q;
    logic              mem_rd_q;
    logic              cache_write_q;

    logic              miss_take;
    logic              line_take;
    logic              hit_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            refill_q      <= 1'b0;
            miss_addr_q   <= '0;
            line_q        <= '0;
            mem_rd_q      <= 1'b0;
            cache_write_q <= 1'b0;
        end else begin
            state         <= state_next;
            // Outputs decoded from the next state so they are registered yet
            // line up with the state they belong to.
            mem_rd_q      <= (state_next == FETCH);
            cache_write_q <= (state_next == FILL);
            if (miss_take) begin
                miss_addr_q <= cpu_addr;
                refill_q    <= 1'b1;
            end else if (cpu_ready) begin
                // The first completion after a refill is the retried access.
                refill_q    <= 1'b0;
            end
            if (line_take) begin
                line_q <= mem_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        cpu_ready  = 1'b0;
        cache_addr = miss_addr_q;
        miss_take  = 1'b0;
        line_take  = 1'b0;
        case (state)
            IDLE: begin
                cache_addr = cpu_addr;
                cpu_ready  = cpu_req & ~cache_miss;
                if (cpu_req && cache_miss) begin
                    miss_take  = 1'b1;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (mem_ready) begin
                    line_take  = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A refilled access counts only as a miss.
    assign hit_inc     = cpu_ready & ~refill_q;

    assign mem_rd      = mem_rd_q;
    assign mem_addr    = line_addr(miss_addr_q);
    assign cache_write = cache_write_q;
    assign cache_wdata = line_q;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_take),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_miss_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_miss_controller
// Self-checking bench: a vector table of hit/idle cycles applied through a
// scoreboard queue, plus hand-written sequences for misses, slow memory,
// reset during a fetch, spurious memory ready and counter saturation.
// ---------------------------------------------------------------------------
module tb_cache_miss_controller;

    localparam int ADDR_W = 15;
    localparam int LINE_W = 128;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              cache_miss;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_write;
    logic [LINE_W-1:0] cache_wdata;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [LINE_W-1:0] mem_data;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    // Narrow-counter instance used only for the saturation sequence.
    logic              s_rst;
    logic              s_req;
    logic              s_ready;
    logic [ADDR_W-1:0] s_cache_addr;
    logic              s_cache_write;
    logic [LINE_W-1:0] s_cache_wdata;
    logic              s_mem_rd;
    logic [ADDR_W-1:0] s_mem_addr;
    logic [3:0]        s_hit_count;
    logic [3:0]        s_miss_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_miss_controller #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_ready   (cpu_ready),
        .cache_miss  (cache_miss),
        .cache_addr  (cache_addr),
        .cache_write (cache_write),
        .cache_wdata (cache_wdata),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .hit_count   (hit_count),
        .miss_count  (miss_count)
    );

    cache_miss_controller #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(4)) dut4 (
        .clk         (clk),
        .rst         (s_rst),
        .cpu_req     (s_req),
        .cpu_addr    (15'h0040),
        .cpu_ready   (s_ready),
        .cache_miss  (1'b0),
        .cache_addr  (s_cache_addr),
        .cache_write (s_cache_write),
        .cache_wdata (s_cache_wdata),
        .mem_rd      (s_mem_rd),
        .mem_addr    (s_mem_addr),
        .mem_ready   (1'b0),
        .mem_data    ({LINE_W{1'b0}}),
        .hit_count   (s_hit_count),
        .miss_count  (s_miss_count)
    );

    typedef struct {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              miss;
        logic              exp_ready;
        logic [ADDR_W-1:0] exp_caddr;
    } vec_t;

    typedef struct {
        logic              ready;
        logic [ADDR_W-1:0] caddr;
        logic              mem_rd;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [LINE_W-1:0] LINE_A5 = {16{8'hA5}};
    localparam logic [LINE_W-1:0] LINE_3C = {8{16'h3C5A}};

    initial begin
        vec_t vecs[6];
        exp_t e;
        int   exp_hits;
        int   rd_cycles;
        int   wr_pulses;
        int   ready_at;
        int   ready_early;
        logic [LINE_W-1:0] wdata_seen;

        rst = 1'b0; s_rst = 1'b0; s_req = 1'b0;
        cpu_req = 1'b0; cpu_addr = '0; cache_miss = 1'b0;
        mem_ready = 1'b0; mem_data = '0;

        // Reset state
        cyc(); cyc();
        @(negedge clk);
        check("rst_mem_rd", {127'b0, mem_rd}, 128'd0);
        check("rst_cache_write", {127'b0, cache_write}, 128'd0);
        check("rst_cache_wdata", cache_wdata, 128'd0);
        check("rst_mem_addr", {113'b0, mem_addr}, 128'd0);
        check("rst_hit_count", {96'b0, hit_count}, 128'd0);
        check("rst_miss_count", {96'b0, miss_count}, 128'd0);
        cyc();
        rst = 1'b1; s_rst = 1'b1;

        // Cold miss at 0x0004, memory answers in cycle 2
        cyc();
        cpu_req = 1'b1; cpu_addr = 15'h0004; cache_miss = 1'b1;
        @(negedge clk);
        check("cold_c0_ready", {127'b0, cpu_ready}, 128'd0);
        check("cold_c0_caddr", {113'b0, cache_addr}, 128'h0004);
        cyc();
        cache_miss = 1'b0;
        @(negedge clk);
        check("cold_c1_mem_rd", {127'b0, mem_rd}, 128'd1);
        check("cold_c1_mem_addr", {113'b0, mem_addr}, 128'h0004);
        check("cold_c1_ready", {127'b0, cpu_ready}, 128'd0);
        check("cold_c1_miss_count", {96'b0, miss_count}, 128'd1);
        cyc();
        mem_ready = 1'b1; mem_data = LINE_A5;
        @(negedge clk);
        check("cold_c2_mem_rd", {127'b0, mem_rd}, 128'd1);
        cyc();
        mem_ready = 1'b0; mem_data = '0;
        @(negedge clk);
        check("cold_c3_cache_write", {127'b0, cache_write}, 128'd1);
        check("cold_c3_wdata", cache_wdata, LINE_A5);
        check("cold_c3_mem_rd", {127'b0, mem_rd}, 128'd0);
        check("cold_c3_ready", {127'b0, cpu_ready}, 128'd0);
        check("cold_c3_caddr", {113'b0, cache_addr}, 128'h0004);
        cyc();
        @(negedge clk);
        check("cold_c4_ready", {127'b0, cpu_ready}, 128'd1);
        check("cold_c4_cache_write", {127'b0, cache_write}, 128'd0);
        cyc();
        cpu_req = 1'b0;
        @(negedge clk);
        check("cold_hit_count", {96'b0, hit_count}, 128'd0);
        check("cold_miss_count", {96'b0, miss_count}, 128'd1);

        // Vector table: back-to-back hits and idle cycles via scoreboard
        vecs[0] = '{1'b1, 15'h0010, 1'b0, 1'b1, 15'h0010};
        vecs[1] = '{1'b1, 15'h7FFC, 1'b0, 1'b1, 15'h7FFC};
        vecs[2] = '{1'b1, 15'h1234, 1'b0, 1'b1, 15'h1234};
        vecs[3] = '{1'b0, 15'h0100, 1'b0, 1'b0, 15'h0100};
        vecs[4] = '{1'b1, 15'h4444, 1'b0, 1'b1, 15'h4444};
        vecs[5] = '{1'b0, 15'h2222, 1'b1, 1'b0, 15'h2222};
        exp_hits = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            cpu_req = vecs[i].req; cpu_addr = vecs[i].addr; cache_miss = vecs[i].miss;
            sb.push_back('{vecs[i].exp_ready, vecs[i].exp_caddr, 1'b0});
            if (vecs[i].req && !vecs[i].miss) exp_hits++;
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("vec%0d_ready", i), {127'b0, cpu_ready}, {127'b0, e.ready});
            check($sformatf("vec%0d_caddr", i), {113'b0, cache_addr}, {113'b0, e.caddr});
            check($sformatf("vec%0d_mem_rd", i), {127'b0, mem_rd}, {127'b0, e.mem_rd});
        end
        cyc();
        cpu_req = 1'b0; cache_miss = 1'b0;
        @(negedge clk);
        check("vec_hit_count", {96'b0, hit_count}, exp_hits);
        check("vec_miss_count", {96'b0, miss_count}, 128'd1);

        // Slow memory: mem_ready on the 10th FETCH cycle
        cyc();
        cpu_req = 1'b1; cpu_addr = 15'h2ABE; cache_miss = 1'b1;
        @(negedge clk);
        rd_cycles = 0; wr_pulses = 0; ready_at = 0; ready_early = 0; wdata_seen = '0;
        for (int i = 1; i <= 20 && ready_at == 0; i++) begin
            cyc();
            cache_miss = 1'b0;
            mem_ready = (i == 10);
            mem_data = (i == 10) ? LINE_3C : '0;
            @(negedge clk);
            if (mem_rd) rd_cycles++;
            if (i == 1) check("slow_mem_addr", {113'b0, mem_addr}, 128'h2ABC);
            if (cache_write) begin
                wr_pulses++;
                wdata_seen = cache_wdata;
            end
            if (cpu_ready) ready_at = i;
        end
        mem_ready = 1'b0; mem_data = '0;
        check("slow_mem_rd_cycles", rd_cycles, 128'd10);
        check("slow_write_pulses", wr_pulses, 128'd1);
        check("slow_wdata", wdata_seen, LINE_3C);
        check("slow_ready_cycle", ready_at, 128'd12);
        cyc();
        cpu_req = 1'b0;
        @(negedge clk);
        check("slow_miss_count", {96'b0, miss_count}, 128'd2);
        check("slow_hit_count", {96'b0, hit_count}, exp_hits);

        // Spurious mem_ready while idle
        for (int i = 0; i < 3; i++) begin
            cyc();
            mem_ready = 1'b1; mem_data = LINE_A5;
            @(negedge clk);
            check($sformatf("spur%0d_mem_rd", i), {127'b0, mem_rd}, 128'd0);
            check($sformatf("spur%0d_cache_write", i), {127'b0, cache_write}, 128'd0);
        end
        cyc();
        mem_ready = 1'b0;
        cpu_req = 1'b1; cpu_addr = 15'h0300; cache_miss = 1'b0;
        @(negedge clk);
        check("spur_hit_after_ready", {127'b0, cpu_ready}, 128'd1);
        check("spur_no_write", {127'b0, cache_write}, 128'd0);
        cyc();
        cpu_req = 1'b0;
        @(negedge clk);
        check("spur_hit_count", {96'b0, hit_count}, exp_hits + 1);

        // Reset in the second FETCH cycle
        cyc();
        cpu_req = 1'b1; cpu_addr = 15'h0008; cache_miss = 1'b1;
        cyc();
        cache_miss = 1'b0;
        @(negedge clk);
        check("rstf_c1_mem_rd", {127'b0, mem_rd}, 128'd1);
        cyc();
        rst = 1'b0;
        mem_ready = 1'b1; mem_data = LINE_A5;
        cyc();
        mem_ready = 1'b0; cpu_req = 1'b0;
        @(negedge clk);
        check("rstf_mem_rd", {127'b0, mem_rd}, 128'd0);
        check("rstf_cache_write", {127'b0, cache_write}, 128'd0);
        check("rstf_hit_count", {96'b0, hit_count}, 128'd0);
        check("rstf_miss_count", {96'b0, miss_count}, 128'd0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        check("rstf_no_write_after", {127'b0, cache_write}, 128'd0);
        check("rstf_mem_rd_after", {127'b0, mem_rd}, 128'd0);

        // Saturation on the 4-bit counter instance
        for (int i = 1; i <= 20; i++) begin
            cyc();
            s_req = 1'b1;
            @(negedge clk);
            if (i == 11) check("sat_count_10", {124'b0, s_hit_count}, 128'd10);
        end
        cyc();
        s_req = 1'b0;
        @(negedge clk);
        check("sat_count_15", {124'b0, s_hit_count}, 128'd15);
        cyc();
        @(negedge clk);
        check("sat_hold_15", {124'b0, s_hit_count}, 128'd15);
        check("sat_miss_count", {124'b0, s_miss_count}, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
